mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide responder that receives the control unit's start pulses for MULT/DIV and returns a completion pulse.
- Sits in the datapath beside the ALU. Operands come from the A/B registers; results drive the HI/LO register inputs.
- Completion feeds the control unit's multiply/divide wait input.
- Radix-2 Booth multiply and restoring signed divide, one iteration per cycle.

---
 rtl/mult_div_unit_pkg.sv | 8 +
 rtl/mult_div_unit_div_core.sv | 39 +++
 rtl/mult_div_unit.sv | 150 +++++++++++++++
 tb/tb_mult_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: shared constants and state encoding for the multiply/divide unit
package mult_div_unit_pkg;
  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = 32;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV = 6'h1A;
  typedef enum logic [2:0] {ST_IDLE, ST_MULT_RUN, ST_DIV_RUN, ST_FIX_SIGN, ST_DONE} state_t;
endpackage

// File: rtl/mult_div_unit_div_core.sv
// mult_div_unit_div_core: restoring unsigned divide on magnitudes, one quotient bit per step
module mult_div_unit_div_core
  import mult_div_unit_pkg::*;
#(
  parameter int W = MDU_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic [W-1:0] quo
);
  logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [W:0] shifted;
  logic [W+1:0] diff;
  assign shifted = {rem_q, quo_q[W-1]};
  assign diff = {1'b0, shifted} - {2'b00, dvs_q};
  always_comb begin
    rem_d = load ? '0 : step ? (diff[W+1] ? shifted[W-1:0] : diff[W-1:0]) : rem_q;
    quo_d = load ? dividend : step ? {quo_q[W-2:0], ~diff[W+1]} : quo_q;
    dvs_d = load ? divisor : dvs_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end
  assign rem = rem_q;
  assign quo = quo_q;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiply / restoring divide feeding HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITERS = MDU_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic qm1_q, qm1_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic done_q, done_d, dz_q, dz_d, busy_q, busy_d;
  logic div_load, div_step;
  logic [WIDTH-1:0] rem, quo, mag_a, mag_b;
  logic [WIDTH:0] ext_acc, ext_m, booth_sum;
  assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;
  // one guard bit keeps acc -= M exact when M is the most negative value
  assign ext_acc = {acc_q[WIDTH-1], acc_q};
  assign ext_m = {m_q[WIDTH-1], m_q};
  assign booth_sum = ({q_q[0], qm1_q} == 2'b01) ? ext_acc + ext_m :
                     ({q_q[0], qm1_q} == 2'b10) ? ext_acc - ext_m : ext_acc;
  mult_div_unit_div_core #(.W(WIDTH)) u_div (
    .clk(clk),
    .reset(reset),
    .load(div_load),
    .step(div_step),
    .dividend(mag_a),
    .divisor(mag_b),
    .rem(rem),
    .quo(quo)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d = q_q;
    qm1_d = qm1_q;
    m_d = m_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    busy_d = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mult_start) begin
          acc_d = '0;
          q_d = op_a;
          qm1_d = 1'b0;
          m_d = op_b;
          cnt_d = '0;
          busy_d = 1'b1;
          state_d = ST_MULT_RUN;
        end else if (div_start && op_b == '0) begin
          done_d = 1'b1;
          dz_d = 1'b1;
          state_d = ST_DONE;
        end else if (div_start) begin
          div_load = 1'b1;
          qneg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          rneg_d = op_a[WIDTH-1];
          cnt_d = '0;
          busy_d = 1'b1;
          state_d = ST_DIV_RUN;
        end
      end
      ST_MULT_RUN: begin
        acc_d = booth_sum[WIDTH:1];
        q_d = {booth_sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CW'(1);
        busy_d = cnt_q != LAST;
        if (cnt_q == LAST) begin
          hi_d = booth_sum[WIDTH:1];
          lo_d = {booth_sum[0], q_q[WIDTH-1:1]};
          done_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DIV_RUN: begin
        div_step = 1'b1;
        cnt_d = cnt_q + CW'(1);
        busy_d = 1'b1;
        state_d = (cnt_q == LAST) ? ST_FIX_SIGN : ST_DIV_RUN;
      end
      ST_FIX_SIGN: begin
        hi_d = rneg_q ? -rem : rem;
        lo_d = qneg_q ? -quo : quo;
        done_d = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      qm1_q <= 1'b0;
      m_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q <= q_d;
      qm1_q <= qm1_d;
      m_q <= m_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dz_q <= dz_d;
      busy_q <= busy_d;
    end
  end
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy = busy_q;
  assign done = done_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, corner sequences and random ops against an arithmetic model
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mult_start = 1'b0;
  logic div_start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi_out, lo_out;
  logic busy, done, div_zero;
  int checks = 0;
  int fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    int kind;
    logic [31:0] a, b, hi, lo;
    logic dz;
    int lat;
    int inj;
    int watch;
  } vec_t;
  vec_t vecs[10];

  mult_div_unit dut (
    .clk(clk),
    .reset(reset),
    .mult_start(mult_start),
    .div_start(div_start),
    .op_a(op_a),
    .op_b(op_b),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // kind: 0 mult, 1 div, 2 both starts; inj>0 pulses both starts with other operands in that cycle
  task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b, input int inj,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    lat = -1;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    op_a = a;
    op_b = b;
    mult_start = (kind != 1);
    div_start = (kind != 0);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      mult_start = 1'b0;
      div_start = 1'b0;
      if (k == inj) begin
        mult_start = 1'b1;
        div_start = 1'b1;
        op_a = 32'd100;
        op_b = 32'd7;
      end
      if (done) begin
        lat = k;
        hi = hi_out;
        lo = lo_out;
        dz = div_zero;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) busy_ok = 1'b0;
    end
    mult_start = 1'b0;
    div_start = 1'b0;
    if (lat > 0) begin
      @(negedge clk);
      chk("done_single_pulse", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic watch_idle(input string name, input int n);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  task automatic model(input int kind, input logic [31:0] a, input logic [31:0] b,
                       output logic e_dz, output int e_lat);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e_dz = 1'b0;
    if (kind == 1 && b == 32'd0) begin
      e_dz = 1'b1;
      e_lat = 1;
    end else if (kind == 1) begin
      q = sa / sb;
      r = sa % sb;
      m_lo = q[31:0];
      m_hi = r[31:0];
      e_lat = 34;
    end else begin
      p = sa * sb;
      m_hi = p[63:32];
      m_lo = p[31:0];
      e_lat = 33;
    end
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    logic dz, busy_ok, e_dz;
    int lat, e_lat, kind, seen;
    vecs[0] = '{0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 0, 0};
    vecs[1] = '{0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 0, 0};
    vecs[2] = '{0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33, 0, 0};
    vecs[3] = '{1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0, 0};
    vecs[4] = '{1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 0, 0};
    vecs[5] = '{1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 0, 0};
    vecs[6] = '{2, 32'd6, 32'd3, 32'd0, 32'd18, 1'b0, 33, 0, 40};
    vecs[7] = '{0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 5, 3};
    vecs[8] = '{0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 0, 0};
    vecs[9] = '{1, 32'd5, 32'd0, 32'd0, 32'd15, 1'b1, 1, 0, 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dz", {63'd0, div_zero}, 64'd0);
    foreach (vecs[i]) begin
      run_op(vecs[i].kind, vecs[i].a, vecs[i].b, vecs[i].inj, hi, lo, dz, lat, busy_ok);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), {63'd0, busy_ok}, 64'd1);
      if (vecs[i].watch > 0) watch_idle($sformatf("vec%0d_quiet_after", i), vecs[i].watch);
    end
    // start ignored while busy, then reset aborts the multiply
    seen = 0;
    op_a = 32'd9;
    op_b = 32'd9;
    mult_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      mult_start = 1'b0;
      div_start = (k == 5);
      if (k == 5) begin
        op_a = 32'd50;
        op_b = 32'd5;
      end
      if (done) seen++;
      if (k == 9) chk("abort_busy_before_reset", {63'd0, busy}, 64'd1);
      if (k == 10) reset = 1'b1;
    end
    chk("abort_no_done_before_reset", 64'(seen), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_hi", 64'(hi_out), 64'd0);
    chk("abort_lo", 64'(lo_out), 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    watch_idle("abort_quiet", 40);
    run_op(0, 32'd3, 32'd4, 0, hi, lo, dz, lat, busy_ok);
    chk("post_abort_hi", 64'(hi), 64'd0);
    chk("post_abort_lo", 64'(lo), 64'd12);
    chk("post_abort_latency", 64'(lat), 64'd33);
    m_hi = hi_out;
    m_lo = lo_out;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) - 32'd10 : $urandom;
      if (kind == 1 && $urandom_range(0, 9) == 0) b = 32'd0;
      model(kind, a, b, e_dz, e_lat);
      run_op(kind, a, b, 0, hi, lo, dz, lat, busy_ok);
      chk($sformatf("rnd%0d_hi k%0d a=%h b=%h", n, kind, a, b), 64'(hi), 64'(m_hi));
      chk($sformatf("rnd%0d_lo k%0d a=%h b=%h", n, kind, a, b), 64'(lo), 64'(m_lo));
      chk($sformatf("rnd%0d_dz", n), {63'd0, dz}, {63'd0, e_dz});
      chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(e_lat));
      chk($sformatf("rnd%0d_busy", n), {63'd0, busy_ok}, 64'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
